// File: rtl/irq_pending_latch.sv
// Request front end for the priority encoder: synchronises raw request lines,
// latches them into sticky pending bits, masks them and clears on acknowledge.
module irq_pending_latch #(
    parameter int                 OUT_SIZE    = 4,
    parameter int                 IN_SIZE     = 1 << OUT_SIZE,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [IN_SIZE-1:0] EDGE_MASK   = '1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_SIZE-1:0]  req,
    input  logic                mask_we,
    input  logic [IN_SIZE-1:0]  mask_in,
    output logic [IN_SIZE-1:0]  mask_q,
    input  logic                ack_valid,
    input  logic [OUT_SIZE-1:0] ack_idx,
    input  logic                clear_all,
    output logic [IN_SIZE-1:0]  pend_out,
    output logic                irq_valid,
    output logic [IN_SIZE-1:0]  pending_raw,
    output logic                overrun
);

    // ack_valid is a single-cycle strobe with no ready: the bit named by
    // ack_idx is cleared on the edge where ack_valid is high. Indices at or
    // above IN_SIZE match no line and are therefore ignored.

    logic [IN_SIZE-1:0] req_s;
    logic [IN_SIZE-1:0] req_h_q;
    logic [IN_SIZE-1:0] rise;
    logic [IN_SIZE-1:0] ack_hit;
    logic [IN_SIZE-1:0] clr;
    logic [IN_SIZE-1:0] pending_q;
    logic [IN_SIZE-1:0] pending_d;
    logic [IN_SIZE-1:0] mask_d;
    logic               overrun_q;
    logic               overrun_d;
    logic               overrun_evt;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign req_s = req;
    end else begin : g_sync
        logic [IN_SIZE-1:0] sync_q [SYNC_STAGES];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < SYNC_STAGES; k++) begin
                    sync_q[k] <= '0;
                end
            end else begin
                sync_q[0] <= req;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_q[k] <= sync_q[k-1];
                end
            end
        end

        assign req_s = sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        ack_hit = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            ack_hit[i] = ack_valid && (32'(ack_idx) == i);
        end
    end

    // Edge history resets to 0, so a line held high through reset release
    // is seen as a fresh rising edge.
    assign rise      = (EDGE_MASK & req_s & ~req_h_q) | (~EDGE_MASK & req_s);
    assign clr       = ack_hit | {IN_SIZE{clear_all}};
    assign pending_d = rise | (pending_q & ~clr);
    assign mask_d    = mask_we ? mask_in : mask_q;

    // A same-cycle ack absorbs the repeat event; clear_all does not, so an
    // event landing with clear_all still leaves overrun set.
    assign overrun_evt = |(EDGE_MASK & rise & pending_q & ~ack_hit);
    assign overrun_d   = overrun_evt | (overrun_q & ~clear_all);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_h_q   <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            req_h_q   <= req_s;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            overrun_q <= overrun_d;
        end
    end

    assign pend_out    = pending_q & mask_q;
    assign irq_valid   = |pend_out;
    assign pending_raw = pending_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Randomised and directed bench for irq_pending_latch against a per-line
// behavioural model of sticky request latching.
module tb_irq_pending_latch;

    localparam int OUT_SIZE    = 4;
    localparam int IN_SIZE     = 16;
    localparam int SYNC_STAGES = 2;
    localparam logic [IN_SIZE-1:0] EDGE_CFG = 16'hFFEF;

    logic                clk;
    logic                rst_n;
    logic [IN_SIZE-1:0]  req;
    logic                mask_we;
    logic [IN_SIZE-1:0]  mask_in;
    logic [IN_SIZE-1:0]  mask_q;
    logic                ack_valid;
    logic [OUT_SIZE-1:0] ack_idx;
    logic                clear_all;
    logic [IN_SIZE-1:0]  pend_out;
    logic                irq_valid;
    logic [IN_SIZE-1:0]  pending_raw;
    logic                overrun;

    int n_checks = 0;
    int n_errors = 0;

    irq_pending_latch #(
        .OUT_SIZE(OUT_SIZE),
        .IN_SIZE(IN_SIZE),
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_MASK(EDGE_CFG)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .mask_we(mask_we),
        .mask_in(mask_in),
        .mask_q(mask_q),
        .ack_valid(ack_valid),
        .ack_idx(ack_idx),
        .clear_all(clear_all),
        .pend_out(pend_out),
        .irq_valid(irq_valid),
        .pending_raw(pending_raw),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each line remembers what it last saw and whether it
    // is pending; raw request samples travel through a queue of SYNC_STAGES.
    logic [IN_SIZE-1:0] m_pend;
    logic [IN_SIZE-1:0] m_mask;
    logic               m_ovr;
    logic [IN_SIZE-1:0] m_prev;
    logic [IN_SIZE-1:0] m_hist[$];
    logic [IN_SIZE-1:0] edge_v;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_mask = '0;
        m_ovr  = 1'b0;
        m_prev = '0;
        m_hist.delete();
        for (int k = 0; k < SYNC_STAGES; k++) m_hist.push_back('0);
    endtask

    task automatic model_step();
        logic [IN_SIZE-1:0] seen;
        logic [IN_SIZE-1:0] nxt;
        logic               ovr_new;
        bit                 event_i;
        bit                 acked;
        if (!rst_n) begin
            model_reset();
            return;
        end
        seen    = (SYNC_STAGES == 0) ? req : m_hist[0];
        nxt     = m_pend;
        ovr_new = 1'b0;
        for (int i = 0; i < IN_SIZE; i++) begin
            if (edge_v[i]) event_i = seen[i] && !m_prev[i];
            else           event_i = seen[i];
            acked = ack_valid && (int'(ack_idx) == i);
            if (event_i && edge_v[i] && m_pend[i] && !acked) ovr_new = 1'b1;
            if (event_i)                 nxt[i] = 1'b1;
            else if (clear_all || acked) nxt[i] = 1'b0;
        end
        m_pend = nxt;
        m_ovr  = ovr_new || (m_ovr && !clear_all);
        if (mask_we) m_mask = mask_in;
        m_prev = seen;
        m_hist.push_back(req);
        void'(m_hist.pop_front());
    endtask

    task automatic check_model();
        check_eq("pending_raw", 32'(pending_raw), 32'(m_pend));
        check_eq("pend_out", 32'(pend_out), 32'(m_pend & m_mask));
        check_eq("irq_valid", 32'(irq_valid), 32'(|(m_pend & m_mask)));
        check_eq("mask_q", 32'(mask_q), 32'(m_mask));
        check_eq("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    // Advance one edge; leaves the caller 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        req       = '0;
        mask_we   = 1'b0;
        mask_in   = '0;
        ack_valid = 1'b0;
        ack_idx   = '0;
        clear_all = 1'b0;
    endtask

    task automatic load_mask(input logic [IN_SIZE-1:0] m);
        mask_we = 1'b1;
        mask_in = m;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic pulse(input logic [IN_SIZE-1:0] lines);
        req = lines;
        tick();
        req = '0;
    endtask

    task automatic ack(input int idx);
        ack_valid = 1'b1;
        ack_idx   = OUT_SIZE'(idx);
        tick();
        ack_valid = 1'b0;
    endtask

    initial begin
        edge_v = EDGE_CFG;
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #12;
        check_eq("reset_pend_out", 32'(pend_out), 32'h0);
        check_eq("reset_irq_valid", 32'(irq_valid), 32'h0);
        check_eq("reset_mask_q", 32'(mask_q), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single pulse: visible two edges after it is sampled, then acked.
        load_mask(16'hFFFF);
        check_eq("t1_mask", 32'(mask_q), 32'hFFFF);
        pulse(16'h0020);
        tick();
        check_eq("t1_not_yet", 32'(pending_raw), 32'h0);
        tick();
        check_eq("t1_pending", 32'(pending_raw), 32'h0020);
        check_eq("t1_irq", 32'(irq_valid), 32'h1);
        ack(5);
        check_eq("t1_ack_pend", 32'(pend_out), 32'h0);
        check_eq("t1_ack_irq", 32'(irq_valid), 32'h0);

        // Two simultaneous rises, acked one at a time.
        pulse(16'h0208);
        tick();
        tick();
        check_eq("t2_both", 32'(pend_out), 32'h0208);
        ack(3);
        check_eq("t2_ack3", 32'(pend_out), 32'h0200);
        ack(9);
        check_eq("t2_ack9", 32'(pend_out), 32'h0000);
        check_eq("t2_irq", 32'(irq_valid), 32'h0);

        // Masked line still latches; unmasking exposes it next edge.
        load_mask(16'h0000);
        pulse(16'h0080);
        tick();
        tick();
        check_eq("t3_raw", 32'(pending_raw), 32'h0080);
        check_eq("t3_masked", 32'(pend_out), 32'h0);
        check_eq("t3_masked_irq", 32'(irq_valid), 32'h0);
        load_mask(16'h0080);
        check_eq("t3_unmask", 32'(pend_out), 32'h0080);
        check_eq("t3_unmask_irq", 32'(irq_valid), 32'h1);
        ack(7);
        load_mask(16'hFFFF);

        // Overrun on a repeated edge, ack colliding with a new rise, clear_all.
        pulse(16'h0004);
        tick();
        tick();
        check_eq("t4_first", 32'(pending_raw), 32'h0004);
        check_eq("t4_no_ovr", 32'(overrun), 32'h0);
        pulse(16'h0004);
        tick();
        tick();
        check_eq("t4_ovr", 32'(overrun), 32'h1);
        check_eq("t4_single", 32'(pending_raw), 32'h0004);
        pulse(16'h0004);
        tick();
        ack(2);
        check_eq("t4_ack_rise", 32'(pending_raw), 32'h0004);
        check_eq("t4_ovr_kept", 32'(overrun), 32'h1);
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        check_eq("t4_clr_pend", 32'(pending_raw), 32'h0);
        check_eq("t4_clr_ovr", 32'(overrun), 32'h0);

        // Level line 4 cannot be acked while held high.
        req = 16'h0010;
        tick();
        tick();
        tick();
        check_eq("t5_set", 32'(pending_raw), 32'h0010);
        ack_valid = 1'b1;
        ack_idx   = 4'd4;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t5_held", 32'(pending_raw), 32'h0010);
        end
        req = '0;
        tick();
        tick();
        tick();
        ack_valid = 1'b0;
        check_eq("t5_cleared", 32'(pending_raw), 32'h0);
        check_eq("t5_no_ovr", 32'(overrun), 32'h0);

        // Asynchronous reset with req[1] held, then re-detection after release.
        req = 16'h0002;
        tick();
        tick();
        tick();
        check_eq("t6_before", 32'(pending_raw), 32'h0002);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("t6_rst_raw", 32'(pending_raw), 32'h0);
        check_eq("t6_rst_pend", 32'(pend_out), 32'h0);
        check_eq("t6_rst_irq", 32'(irq_valid), 32'h0);
        check_eq("t6_rst_mask", 32'(mask_q), 32'h0);
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("t6_wait", 32'(pending_raw), 32'h0);
        tick();
        check_eq("t6_redetect", 32'(pending_raw), 32'h0002);
        req = '0;
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        load_mask(16'hFFFF);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            req       = IN_SIZE'($urandom & $urandom & $urandom);
            mask_we   = ($urandom_range(0, 14) == 0);
            mask_in   = IN_SIZE'($urandom | $urandom);
            clear_all = ($urandom_range(0, 39) == 0);
            ack_valid = 1'b0;
            ack_idx   = OUT_SIZE'($urandom_range(0, IN_SIZE - 1));
            if ($urandom_range(0, 3) == 0) begin
                ack_valid = 1'b1;
            end else if (|(m_pend & m_mask) && $urandom_range(0, 1) == 1) begin
                ack_valid = 1'b1;
                for (int i = IN_SIZE - 1; i >= 0; i--) begin
                    if (m_pend[i] && m_mask[i]) ack_idx = OUT_SIZE'(i);
                end
            end
            tick();
        end
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
